sp_ram_be_pipe: RTL and testbench

//  Parametrised single-port synchronous RAM, successor to the basic 8x16 RAM.

---
 rtl/sp_ram_be_pipe.sv | 135 +++++++++++++
 tb/tb_sp_ram_be_pipe.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sp_ram_be_pipe.sv
// Single-port synchronous RAM with byte-lane write enables, registered read data and a post-reset clear sequencer.
// Latency: RD_LAT clocks from an accepted read to data_out/rd_valid (1 or 2); writes land on the accepting edge.
// Backpressure: none; requests arriving while busy (clear in progress) or with cs=0 are dropped, never stalled.
//
// Ports:
//   clk, reset_n         rising-edge clock, asynchronous active-low reset
//   cs, wr_en, rd_en     chip select and access requests (qualified by cs and !busy)
//   be                   byte-lane write enables, lane i = bits [i*BYTE_W +: BYTE_W]
//   address_in, data_in  word address and write data
//   data_out, rd_valid   registered read data and its 1-cycle valid pulse
//   busy                 high while the clear sequencer owns the array
module sp_ram_be_pipe #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 4,
    parameter int BYTE_W         = 8,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       cs,
    input  logic                       wr_en,
    input  logic                       rd_en,
    input  logic [DATA_W/BYTE_W-1:0]   be,
    input  logic [ADDR_W-1:0]          address_in,
    input  logic [DATA_W-1:0]          data_in,
    output logic [DATA_W-1:0]          data_out,
    output logic                       rd_valid,
    output logic                       busy
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_busy;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    // First read stage: array output register, holds its value between reads.
    logic [DATA_W-1:0]   r_rd_dat;
    logic                r_rd_vld;

    logic                w_wr;
    logic                w_rd;

    assign w_wr = cs & wr_en & ~r_busy;
    assign w_rd = cs & rd_en & ~r_busy;
    assign busy = r_busy;

    // Clear sequencer. busy is kept as its own flop alongside the state so the
    // output comes straight from a register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            r_busy    <= (CLEAR_ON_RESET != 0);
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    // Leave on the edge that zeroes the last word: busy lasts DEPTH cycles.
                    if (r_clr_cnt == ADDR_W'(DEPTH - 1)) begin
                        r_state <= ST_READY;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_READY;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Array: no reset on the storage itself; the sequencer zeroes it instead.
    always_ff @(posedge clk) begin
        if (r_busy) begin
            r_mem[r_clr_cnt] <= '0;
        end else if (w_wr) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) begin
                    r_mem[address_in][i*BYTE_W +: BYTE_W] <= data_in[i*BYTE_W +: BYTE_W];
                end
            end
        end
    end

    // Non-blocking read of the array yields the pre-write word on a combined
    // read+write cycle (read-before-write).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_dat <= '0;
            r_rd_vld <= 1'b0;
        end else begin
            r_rd_vld <= w_rd;
            if (w_rd) begin
                r_rd_dat <= r_mem[address_in];
            end
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign data_out = r_rd_dat;
            assign rd_valid = r_rd_vld;
        end else begin : g_lat2
            // Second stage only captures when stage one carries a completed read,
            // so data_out holds the last read value otherwise.
            logic [DATA_W-1:0] r_out_dat;
            logic              r_out_vld;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_out_dat <= '0;
                    r_out_vld <= 1'b0;
                end else begin
                    r_out_vld <= r_rd_vld;
                    if (r_rd_vld) begin
                        r_out_dat <= r_rd_dat;
                    end
                end
            end

            assign data_out = r_out_dat;
            assign rd_valid = r_out_vld;
        end
    endgenerate

endmodule

// File: tb/tb_sp_ram_be_pipe.sv
// Directed bench: drives one stimulus stream into an RD_LAT=1 and an RD_LAT=2 instance,
// plus a CLEAR_ON_RESET=0 instance for its reset-state busy value.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sp_ram_be_pipe;

    logic        clk;
    logic        reset_n;
    logic        cs;
    logic        wr_en;
    logic        rd_en;
    logic [3:0]  be;
    logic [3:0]  address_in;
    logic [31:0] data_in;

    logic [31:0] dout1, dout2, dout0;
    logic        vld1, vld2, vld0;
    logic        busy1, busy2, busy0;

    int checks   = 0;
    int failures = 0;

    sp_ram_be_pipe #(.DATA_W(32), .ADDR_W(4), .BYTE_W(8), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .be(be),
        .address_in(address_in), .data_in(data_in),
        .data_out(dout1), .rd_valid(vld1), .busy(busy1)
    );

    sp_ram_be_pipe #(.DATA_W(32), .ADDR_W(4), .BYTE_W(8), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .be(be),
        .address_in(address_in), .data_in(data_in),
        .data_out(dout2), .rd_valid(vld2), .busy(busy2)
    );

    sp_ram_be_pipe #(.DATA_W(32), .ADDR_W(4), .BYTE_W(8), .RD_LAT(1), .CLEAR_ON_RESET(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .wr_en(wr_en), .rd_en(rd_en), .be(be),
        .address_in(address_in), .data_in(data_in),
        .data_out(dout0), .rd_valid(vld0), .busy(busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cs = 1'b0; wr_en = 1'b0; rd_en = 1'b0; be = 4'h0; address_in = 4'h0; data_in = 32'h0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
        cs = 1'b1; wr_en = 1'b1; rd_en = 1'b0; address_in = a; data_in = d; be = b;
        cyc();
        idle();
    endtask

    // Single read; checks both latencies and the hold of data_out afterwards.
    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        cs = 1'b1; rd_en = 1'b1; wr_en = 1'b0; address_in = a;
        cyc();
        idle();
        chk({tag, "_l1_vld"}, {31'b0, vld1}, 32'd1);
        chk({tag, "_l1_dat"}, dout1, exp);
        chk({tag, "_l2_novld_yet"}, {31'b0, vld2}, 32'd0);
        cyc();
        chk({tag, "_l1_vld_drop"}, {31'b0, vld1}, 32'd0);
        chk({tag, "_l1_hold"}, dout1, exp);
        chk({tag, "_l2_vld"}, {31'b0, vld2}, 32'd1);
        chk({tag, "_l2_dat"}, dout2, exp);
        cyc();
        chk({tag, "_l2_vld_drop"}, {31'b0, vld2}, 32'd0);
        chk({tag, "_l2_hold"}, dout2, exp);
    endtask

    // Count edges until busy falls, bounded; requests held on the inputs must not produce rd_valid.
    task automatic wait_clear(input string tag);
        int n;
        n = 0;
        while (busy1 === 1'b1 && n < 40) begin
            cyc();
            n++;
            chk({tag, "_no_vld1"}, {31'b0, vld1}, 32'd0);
            chk({tag, "_no_vld2"}, {31'b0, vld2}, 32'd0);
        end
        idle();
        chk({tag, "_busy_cycles"}, n, 32'd16);
        chk({tag, "_busy1_low"}, {31'b0, busy1}, 32'd0);
        chk({tag, "_busy2_low"}, {31'b0, busy2}, 32'd0);
    endtask

    initial begin
        logic [31:0] pat;
        reset_n = 1'b0;
        idle();
        cyc();
        cyc();

        // Reset state.
        chk("rst_busy1", {31'b0, busy1}, 32'd1);
        chk("rst_busy2", {31'b0, busy2}, 32'd1);
        chk("rst_busy_noclear", {31'b0, busy0}, 32'd0);
        chk("rst_dout1", dout1, 32'h0);
        chk("rst_dout2", dout2, 32'h0);
        chk("rst_vld1", {31'b0, vld1}, 32'd0);
        chk("rst_vld2", {31'b0, vld2}, 32'd0);

        // T1: clear takes 16 cycles, then every word reads 0.
        reset_n = 1'b1;
        chk("rel_busy_noclear", {31'b0, busy0}, 32'd0);
        wait_clear("t1");
        for (int a = 0; a < 16; a++) begin
            cs = 1'b1; rd_en = 1'b1; address_in = 4'(a);
            cyc();
            chk("t1_l1_vld", {31'b0, vld1}, 32'd1);
            chk("t1_l1_dat", dout1, 32'h0);
            if (a > 0) begin
                chk("t1_l2_vld", {31'b0, vld2}, 32'd1);
                chk("t1_l2_dat", dout2, 32'h0);
            end
        end
        idle();
        cyc();
        chk("t1_l2_last_vld", {31'b0, vld2}, 32'd1);
        chk("t1_l1_end_vld", {31'b0, vld1}, 32'd0);
        cyc();

        // T2: byte-lane merge, and be=0 writes nothing.
        wr(4'd3, 32'hAABB_CCDD, 4'b1111);
        wr(4'd3, 32'h1122_3344, 4'b0101);
        rd("t2_merge", 4'd3, 32'hAA22_CC44);
        wr(4'd3, 32'h0000_0000, 4'b0000);
        rd("t2_be0", 4'd3, 32'hAA22_CC44);
        wr(4'd3, 32'h5566_7788, 4'b1000);
        rd("t2_top", 4'd3, 32'h5522_CC44);

        // T3: simultaneous read and write returns the old word.
        wr(4'd5, 32'h0000_0005, 4'b1111);
        cs = 1'b1; wr_en = 1'b1; rd_en = 1'b1; address_in = 4'd5; data_in = 32'hFFFF_FFFF; be = 4'hF;
        cyc();
        idle();
        chk("t3_l1_vld", {31'b0, vld1}, 32'd1);
        chk("t3_l1_old", dout1, 32'h0000_0005);
        cyc();
        chk("t3_l2_vld", {31'b0, vld2}, 32'd1);
        chk("t3_l2_old", dout2, 32'h0000_0005);
        cyc();
        rd("t3_new", 4'd5, 32'hFFFF_FFFF);

        // T4: requests with cs=0 are dropped.
        cs = 1'b0; wr_en = 1'b1; rd_en = 1'b1; address_in = 4'd3; data_in = 32'h0BAD_0BAD; be = 4'hF;
        cyc();
        chk("t4_cs0_vld1", {31'b0, vld1}, 32'd0);
        cyc();
        chk("t4_cs0_vld2", {31'b0, vld2}, 32'd0);
        idle();
        rd("t4_unchanged", 4'd3, 32'h5522_CC44);

        // T6: fill all words, then back-to-back reads in address order.
        for (int a = 0; a < 16; a++) begin
            wr(4'(a), 32'h1000_0000 + 32'(a), 4'hF);
        end
        for (int a = 0; a < 16; a++) begin
            cs = 1'b1; rd_en = 1'b1; address_in = 4'(a);
            cyc();
            chk("t6_l1_vld", {31'b0, vld1}, 32'd1);
            chk("t6_l1_dat", dout1, 32'h1000_0000 + 32'(a));
            if (a == 0) begin
                chk("t6_l2_first_novld", {31'b0, vld2}, 32'd0);
            end else begin
                chk("t6_l2_vld", {31'b0, vld2}, 32'd1);
                chk("t6_l2_dat", dout2, 32'h1000_0000 + 32'(a - 1));
            end
        end
        idle();
        cyc();
        chk("t6_l2_last_vld", {31'b0, vld2}, 32'd1);
        chk("t6_l2_last_dat", dout2, 32'h1000_000F);
        chk("t6_l1_end_vld", {31'b0, vld1}, 32'd0);
        cyc();
        chk("t6_l2_end_vld", {31'b0, vld2}, 32'd0);

        // T5: reset, run 7 clear cycles, reset again mid-clear.
        reset_n = 1'b0;
        #2;
        chk("t5_rst_dout1", dout1, 32'h0);
        chk("t5_rst_dout2", dout2, 32'h0);
        reset_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            cyc();
        end
        chk("t5_mid_busy", {31'b0, busy1}, 32'd1);
        reset_n = 1'b0;
        #2;
        chk("t5_mid_rst_busy", {31'b0, busy1}, 32'd1);
        reset_n = 1'b1;
        // Read and write to addr 2 held throughout the clear must be ignored.
        cs = 1'b1; rd_en = 1'b1; wr_en = 1'b1; address_in = 4'd2; data_in = 32'h0000_1234; be = 4'hF;
        wait_clear("t5");
        rd("t5_addr2", 4'd2, 32'h0);
        rd("t5_addr3", 4'd3, 32'h0);
        rd("t5_addr12", 4'd12, 32'h0);

        pat = 32'hC0DE_0000;
        wr(4'd9, pat, 4'b0011);
        rd("t5_post_write", 4'd9, 32'h0000_0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
